// File: rtl/ibex_instr_mem_responder.sv
// Memory-side responder for the instruction-fetch bus: grants word fetches under an
// outstanding limit and returns data in order after RespLatency cycles. Macro: IBEX_IMEM_GNT_STALL_EN.
module ibex_instr_mem_responder #(
   parameter int unsigned MemWords       = 1024,
   parameter int unsigned RespLatency    = 1,
   parameter int unsigned MaxOutstanding = 2,
   parameter logic [15:0] LfsrSeed       = 16'hACE1,
   localparam int unsigned AW = $clog2(MemWords),
   localparam int unsigned OW = $clog2(MaxOutstanding + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          instr_req_i,
   input  logic [31:0]   instr_addr_i,
   output logic          instr_gnt_o,
   output logic          instr_rvalid_o,
   output logic [31:0]   instr_rdata_o,
   input  logic          load_we_i,
   input  logic [AW-1:0] load_addr_i,
   input  logic [31:0]   load_wdata_i,
   output logic          misaligned_o,
   output logic [OW-1:0] outstanding_o
);

   logic [31:0]            mem [MemWords];
   logic [RespLatency-1:0] vld_pipe;
   logic [AW-1:0]          idx_pipe [RespLatency];
   logic [OW-1:0]          outstanding_q;
   logic [OW-1:0]          pending_cnt;
   logic [AW-1:0]          idx;
   logic                   stall;
   logic                   gnt;
   logic                   rvalid;
   logic                   unused_addr;

   assign idx         = instr_addr_i[AW+1:2];
   assign unused_addr = ^instr_addr_i[31:AW+2];
   assign rvalid      = vld_pipe[RespLatency-1];

   // The response leaving this cycle frees its slot for a same-cycle grant.
   assign pending_cnt = outstanding_q - OW'(rvalid);
   assign gnt         = instr_req_i & (pending_cnt < OW'(MaxOutstanding)) & ~stall;

   assign instr_gnt_o    = gnt;
   assign instr_rvalid_o = rvalid;
   assign instr_rdata_o  = rvalid ? mem[idx_pipe[RespLatency-1]] : 32'h0;
   assign outstanding_o  = outstanding_q;

`ifdef IBEX_IMEM_GNT_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= LfsrSeed;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe      <= '0;
         outstanding_q <= '0;
         misaligned_o  <= 1'b0;
      end else begin
         vld_pipe[0] <= gnt;
         for (int i = 1; i < RespLatency; i++) vld_pipe[i] <= vld_pipe[i-1];
         outstanding_q <= outstanding_q + OW'(gnt) - OW'(rvalid);
         if (gnt && (instr_addr_i[1:0] != 2'b00)) misaligned_o <= 1'b1;
      end
   end

   // Index stages carry no reset; they are only observed behind a valid bit.
   always_ff @(posedge clk_i) begin
      idx_pipe[0] <= idx;
      for (int i = 1; i < RespLatency; i++) idx_pipe[i] <= idx_pipe[i-1];
   end

   always_ff @(posedge clk_i) begin
      if (load_we_i) mem[load_addr_i] <= load_wdata_i;
   end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder: two configurations share stimulus and are checked
// every cycle against a grant-history model, plus directed scenario checks.
module tb_ibex_instr_mem_responder;

   localparam int MAXC = 1024;

   logic        clk = 1'b0;
   logic        rst, req, we;
   logic [31:0] addr, wdata;
   logic [9:0]  waddr;
   logic        gnt [2];
   logic        rv  [2];
   logic [31:0] rd  [2];
   logic        mis [2];
   logic [1:0]  os0;
   logic [0:0]  os1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_rst = -1;
   bit chk_en = 1'b0;

   // Model state: which cycles produced a captured grant, and for which word.
   bit          cap  [2][MAXC];
   int unsigned cidx [2][MAXC];
   bit          mis_m [2];
   logic [31:0] mem_m [1024];

   logic [31:0] rd0_s;
   logic        g1_s;
   logic [6:0]  pat;

   always #5 clk = ~clk;

   ibex_instr_mem_responder #(.MemWords(1024), .RespLatency(1), .MaxOutstanding(2)) u0 (
      .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]),
      .load_we_i(we), .load_addr_i(waddr), .load_wdata_i(wdata),
      .misaligned_o(mis[0]), .outstanding_o(os0));

   ibex_instr_mem_responder #(.MemWords(1024), .RespLatency(3), .MaxOutstanding(1)) u1 (
      .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]),
      .load_we_i(we), .load_addr_i(waddr), .load_wdata_i(wdata),
      .misaligned_o(mis[1]), .outstanding_o(os1));

   function automatic int rl(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int mo(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One bus cycle: drive, check at negedge against the model, advance model, cross posedge.
   task automatic step(input logic r, input logic q, input logic [31:0] a,
                       input logic w, input logic [9:0] wa, input logic [31:0] wd);
      logic gnt_e [2];
      rst = r; req = q; addr = a; we = w; waddr = wa; wdata = wd;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         int lo, os, start;
         logic rv_e;
         logic [31:0] rd_e, os_obs;
         lo    = cyc - rl(d);
         rv_e  = (lo > last_rst) ? cap[d][lo] : 1'b0;
         start = (lo > last_rst) ? lo : last_rst + 1;
         os = 0;
         for (int g = start; g < cyc; g++) if (cap[d][g]) os++;
         gnt_e[d] = q && ((os - int'(rv_e)) < mo(d));
         rd_e   = rv_e ? mem_m[cidx[d][lo]] : 32'h0;
         os_obs = (d == 0) ? 32'(os0) : 32'(os1);
         if (chk_en) begin
            chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(gnt_e[d]));
            chk($sformatf("rvalid%0d", d), 32'(rv[d]), 32'(rv_e));
            chk($sformatf("rdata%0d", d), rd[d], rd_e);
            chk($sformatf("outstanding%0d", d), os_obs, 32'(os));
            chk($sformatf("misaligned%0d", d), 32'(mis[d]), 32'(mis_m[d]));
         end
      end
      rd0_s = rd[0];
      g1_s  = gnt[1];
      for (int d = 0; d < 2; d++) begin
         cap[d][cyc]  = gnt_e[d] && !r;
         cidx[d][cyc] = a[11:2];
         if (r) mis_m[d] = 1'b0;
         else if (gnt_e[d] && (a[1:0] != 2'b00)) mis_m[d] = 1'b1;
      end
      if (w) mem_m[wa] = wd;
      if (r) last_rst = cyc;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; waddr = '0; wdata = '0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);
      chk_en = 1'b1;
      step(1'b1, 1'b0, 32'h0, 1'b0, 10'h0, 32'h0);

      // Preload words 0..15; the first four carry known values.
      for (int i = 0; i < 16; i++)
         step(1'b0, 1'b0, 32'h0, 1'b1, 10'(i), (i < 4) ? 32'(32'h11 * (i + 1)) : $urandom);

      // Back-to-back fetches at 1-cycle latency.
      step(1'b0, 1'b1, 32'h0, 1'b0, 10'h0, 32'h0);
      step(1'b0, 1'b1, 32'h4, 1'b0, 10'h0, 32'h0);
      chk("s1_word0", rd0_s, 32'h11);
      step(1'b0, 1'b1, 32'h8, 1'b0, 10'h0, 32'h0);
      chk("s1_word1", rd0_s, 32'h22);
      step(1'b0, 1'b1, 32'hC, 1'b0, 10'h0, 32'h0);
      chk("s1_word2", rd0_s, 32'h33);
      idle(1);
      chk("s1_word3", rd0_s, 32'h44);
      idle(4);

      // Latency 3, limit 1: grants every third cycle.
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 32'h0, 1'b0, 10'h0, 32'h0);
         pat[i] = g1_s;
      end
      chk("u1_gnt_pattern", 32'(pat), 32'(7'b1001001));
      idle(4);

      // Upper address bits wrap.
      step(1'b0, 1'b1, 32'h0000_1004, 1'b0, 10'h0, 32'h0);
      idle(1);
      chk("wrap_rdata", rd0_s, 32'h22);
      idle(3);

      // Misaligned fetch is sticky and reads the truncated word.
      step(1'b0, 1'b1, 32'h6, 1'b0, 10'h0, 32'h0);
      chk("mis_set", 32'(mis[0]), 32'h1);
      idle(1);
      chk("mis_rdata", rd0_s, 32'h22);
      idle(2);
      chk("mis_sticky", 32'(mis[0]), 32'h1);
      idle(2);

      // Backdoor write colliding with the response of the same word.
      step(1'b0, 1'b1, 32'h8, 1'b0, 10'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 10'd2, 32'hDEAD);
      chk("collide_old", rd0_s, 32'h33);
      idle(3);
      step(1'b0, 1'b1, 32'h8, 1'b0, 10'h0, 32'h0);
      idle(1);
      chk("collide_new", rd0_s, 32'hDEAD);
      idle(3);

      // Reset with responses in flight drops them.
      step(1'b0, 1'b1, 32'h0, 1'b0, 10'h0, 32'h0);
      step(1'b0, 1'b1, 32'h4, 1'b0, 10'h0, 32'h0);
      step(1'b1, 1'b1, 32'h6, 1'b0, 10'h0, 32'h0);
      chk("rst_outstanding", 32'(os0), 32'h0);
      chk("rst_misaligned", 32'(mis[0]), 32'h0);
      chk("rst_rvalid1", 32'(rv[1]), 32'h0);
      idle(4);

      // Random traffic with occasional resets and backdoor writes.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = $urandom;
         a[11:2] = 10'($urandom_range(0, 15));
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, a,
              $urandom_range(0, 3) == 0, 10'($urandom_range(0, 15)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
